alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Purpose: accepts one ALU op request, drives registered operands and control to an external ALU, and returns the captured result.
// Latency: a request accepted at edge N gives rsp_valid from edge N+1; with rsp_ready high, req_ready returns from edge N+2.
// Backpressure: req_ready is high only in IDLE; a response is held in RESP until rsp_ready is sampled high.
module alu_op_sequencer #(
    parameter int DW          = 32,
    parameter bit ILLEGAL_ERR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
    output logic          rsp_taken,
    output logic          rsp_err,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_ctr,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q;
    logic [3:0]    ctr_q;
    logic [DW-1:0] a_q, b_q, result_q;
    logic          taken_q, err_q;
    logic          accept;
    logic          illegal;
    logic          taken_d;
    logic          err_d;

    // Branch ops reuse the SUB/SLT/SLTU datapath; illegal codes fall back to ADD control.
    function automatic logic [3:0] decode_ctr(input logic [3:0] op);
        case (op)
            4'd0:                 decode_ctr = 4'b0000;
            4'd1, 4'd8, 4'd9:     decode_ctr = 4'b1000;
            4'd2, 4'd10, 4'd11:   decode_ctr = 4'b0010;
            4'd3, 4'd12, 4'd13:   decode_ctr = 4'b0011;
            4'd4:                 decode_ctr = 4'b0110;
            4'd5:                 decode_ctr = 4'b1111;
            default:              decode_ctr = 4'b0000;
        endcase
    endfunction

    assign accept = (state_q == IDLE) && req_valid;

    // Next state plus branch/illegal evaluation of the latched op against the ALU outputs.
    always_comb begin
        state_d = state_q;
        taken_d = 1'b0;
        illegal = 1'b0;
        case (op_q)
            4'd8:                 taken_d = alu_zero;
            4'd9:                 taken_d = !alu_zero;
            4'd10, 4'd12:         taken_d = alu_result[0];
            4'd11, 4'd13:         taken_d = !alu_result[0];
            4'd0, 4'd1, 4'd2,
            4'd3, 4'd4, 4'd5:     taken_d = 1'b0;
            default:              illegal = 1'b1;
        endcase
        err_d = illegal && ILLEGAL_ERR;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand/control registers feeding the ALU, held until the next accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            ctr_q <= 4'b0000;
            op_q  <= 4'd0;
        end else if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            ctr_q <= decode_ctr(req_op);
            op_q  <= req_op;
        end
    end

    // Response capture at the closing edge of EXEC; an error response carries a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (state_q == EXEC) begin
            result_q <= err_d ? '0 : alu_result;
            taken_q  <= taken_d;
            err_q    <= err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctr    = ctr_q;
    assign rsp_result = result_q;
    assign rsp_taken  = taken_q;
    assign rsp_err    = err_q;
    assign rsp_valid  = (state_q == RESP);
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule
